// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_W data bits LSB-first, optional parity, 1-2 stops.
// Parity state and latch are compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic              stop_cnt_q;
    logic              tx_q;
    logic              busy_q;
    logic              last_stop;
    logic              accept;

`ifdef UART_TX_PARITY_EN
    logic parity_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign last_stop = (state_q == StStop) && (stop_cnt_q == 1'(STOP_BITS - 1));
    // Accepts land only on bit boundaries, so a new start bit always gets a full period.
    assign ready_out = rst_n & baud_tick & ((state_q == StIdle) | last_stop);
    assign accept    = valid_in & ready_out;
    assign tx        = tx_q;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (accept) begin
            state_q    <= StStart;
            shift_q    <= data_in;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= (^data_in) ^ (PARITY_ODD != 0);
`endif
        end else if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                end
                StStart: begin
                    state_q   <= StData;
                    bit_cnt_q <= '0;
                    tx_q      <= shift_q[0];
                    shift_q   <= shift_q >> 1;
                end
                StData: begin
                    if (bit_cnt_q == CntW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_q    <= StParity;
                        tx_q       <= parity_q;
`else
                        state_q    <= StStop;
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
`endif
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    state_q    <= StStop;
                    tx_q       <= 1'b1;
                    stop_cnt_q <= 1'b0;
                end
`endif
                StStop: begin
                    if (last_stop) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end else begin
                        stop_cnt_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three instances (8-bit even, 5-bit/2-stop odd, 8-bit odd),
// baud_tick every 4 clocks, tx sampled on falling edges.
module tb_uart_tx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] div_q = 2'd0;
    logic       baud_tick;
    always @(posedge clk) div_q <= div_q + 2'd1;
    assign baud_tick = (div_q == 2'd3);

    logic [7:0] data_r  [3];
    logic       valid_r [3];
    logic       ready_w [3];
    logic       tx_w    [3];
    logic       busy_w  [3];

    int n_cmp = 0;
    int n_err = 0;

`ifdef UART_TX_PARITY_EN
    localparam int          L8     = 11;
    localparam int          L5     = 9;
    localparam logic [31:0] FrA5   = 32'({1'b1, 1'b0, 8'hA5, 1'b0});
    localparam logic [31:0] Fr07e  = 32'({1'b1, 1'b1, 8'h07, 1'b0});
    localparam logic [31:0] Fr07o  = 32'({1'b1, 1'b0, 8'h07, 1'b0});
    localparam logic [31:0] Fr5    = 32'({2'b11, 1'b0, 5'b10011, 1'b0});
    localparam logic [31:0] Fr55_3C = 32'({1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0});
`else
    localparam int          L8     = 10;
    localparam int          L5     = 8;
    localparam logic [31:0] FrA5   = 32'({1'b1, 8'hA5, 1'b0});
    localparam logic [31:0] Fr07e  = 32'({1'b1, 8'h07, 1'b0});
    localparam logic [31:0] Fr07o  = 32'({1'b1, 8'h07, 1'b0});
    localparam logic [31:0] Fr5    = 32'({2'b11, 5'b10011, 1'b0});
    localparam logic [31:0] Fr55_3C = 32'({1'b1, 8'h3C, 1'b0, 1'b1, 8'h55, 1'b0});
`endif

    uart_tx_param #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data_in(data_r[0]),
        .valid_in(valid_r[0]), .ready_out(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0])
    );

    uart_tx_param #(.DATA_W(5), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data_in(data_r[1][4:0]),
        .valid_in(valid_r[1]), .ready_out(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1])
    );

    uart_tx_param #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data_in(data_r[2]),
        .valid_in(valid_r[2]), .ready_out(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2])
    );

    // Present a word and hold it until the handshake edge; returns just after that edge.
    task automatic accept_word(input int idx, input logic [7:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        valid_r[idx] = 1'b1;
        data_r[idx]  = d;
        #1;
        while (!ready_w[idx] && waited < 16) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_cmp++;
        if (ready_w[idx] !== 1'b1) begin
            n_err++;
            $display("FAIL accept_%0d: ready_out got %b want 1 within 16 cycles", idx, ready_w[idx]);
        end
        @(posedge clk);
        #1;
        valid_r[idx] = 1'b0;
        data_r[idx]  = ~d;
    endtask

    task automatic run_frame(input int idx, input logic [31:0] exp, input int nbits,
                             input string name);
        for (int j = 0; j < nbits * 4; j++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_w[idx] !== exp[j / 4] || busy_w[idx] !== 1'b1) begin
                n_err++;
                $display("FAIL %s cycle %0d: tx/busy got %b/%b want %b/1", name, j, tx_w[idx],
                         busy_w[idx], exp[j / 4]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (tx_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0) begin
            n_err++;
            $display("FAIL %s end: tx/busy got %b/%b want 1/0", name, tx_w[idx], busy_w[idx]);
        end
    endtask

    task automatic test_reset();
        int waited;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_r[i] = 1'b1;
            data_r[i]  = 8'hFF;
        end
        repeat (3) @(negedge clk);
        waited = 0;
        while (!baud_tick && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ready_w[i] !== 1'b0 || tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_%0d: ready/tx/busy got %b/%b/%b want 0/1/0", i, ready_w[i],
                         tx_w[i], busy_w[i]);
            end
            valid_r[i] = 1'b0;
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0) begin
                n_err++;
                $display("FAIL idle_%0d: tx/busy got %b/%b want 1/0", i, tx_w[i], busy_w[i]);
            end
        end
    endtask

    task automatic test_8n1();
        accept_word(0, 8'hA5);
        run_frame(0, FrA5, L8, "frame_a5");
    endtask

    task automatic test_parity_even();
        accept_word(0, 8'h07);
        run_frame(0, Fr07e, L8, "frame_07_even");
    endtask

    // valid rises two cycles ahead of the tick: ready must wait for the tick cycle.
    task automatic test_ready_wait();
        int waited;
        waited = 0;
        @(negedge clk);
        while (div_q != 2'd1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        valid_r[2] = 1'b1;
        data_r[2]  = 8'h07;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (ready_w[2] !== (k == 2)) begin
                n_err++;
                $display("FAIL ready_wait_%0d: ready_out got %b want %b", k, ready_w[2], k == 2);
            end
        end
        @(posedge clk);
        #1;
        valid_r[2] = 1'b0;
        data_r[2]  = 8'h00;
        n_cmp++;
        if (tx_w[2] !== 1'b0 || busy_w[2] !== 1'b1) begin
            n_err++;
            $display("FAIL ready_wait_start: tx/busy got %b/%b want 0/1", tx_w[2], busy_w[2]);
        end
        run_frame(2, Fr07o, L8, "frame_07_odd");
    endtask

    task automatic test_data5_stop2();
        accept_word(1, 8'h13);
        run_frame(1, Fr5, L5, "frame_5b_2stop");
    endtask

    task automatic test_back_to_back();
        int  acc;
        bit  drop;
        acc  = 0;
        drop = 1'b0;
        @(negedge clk);
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h55;
        accept_word(0, 8'h55);
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h3C;
        for (int j = 0; j < 2 * L8 * 4; j++) begin
            @(negedge clk);
            if (drop) begin
                valid_r[0] = 1'b0;
                data_r[0]  = 8'h00;
                drop       = 1'b0;
            end
            n_cmp++;
            if (tx_w[0] !== Fr55_3C[j / 4] || busy_w[0] !== 1'b1) begin
                n_err++;
                $display("FAIL b2b cycle %0d: tx/busy got %b/%b want %b/1", j, tx_w[0], busy_w[0],
                         Fr55_3C[j / 4]);
            end
            if (valid_r[0] && ready_w[0]) begin
                acc++;
                drop = 1'b1;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || acc != 1) begin
            n_err++;
            $display("FAIL b2b end: tx/busy/accepts got %b/%b/%0d want 1/0/1", tx_w[0],
                     busy_w[0], acc);
        end
    endtask

    task automatic test_reset_mid_frame();
        accept_word(0, 8'hA5);
        repeat (17) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: tx/busy got %b/%b want 1/0", tx_w[0], busy_w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: tx/busy got %b/%b want 1/0", tx_w[0], busy_w[0]);
        end
        accept_word(0, 8'hA5);
        run_frame(0, FrA5, L8, "frame_after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            valid_r[i] = 1'b0;
            data_r[i]  = 8'h00;
        end
        test_reset();
        test_8n1();
        test_parity_even();
        test_ready_wait();
        test_data5_stop2();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
